// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter/sequencer sharing the single-ported memory between fetch (rq0) and load/store (rq1).
// Optional WAIT timeout with error completion: define MEM_PORT_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rq0_read,
  input  logic              rq0_write,
  input  logic [ADDR_W-1:0] rq0_addr,
  input  logic [DATA_W-1:0] rq0_wdata,
  output logic              rq0_gnt,
  output logic [DATA_W-1:0] rq0_rdata,
  output logic              rq0_done,
  output logic              rq0_err,
  input  logic              rq1_read,
  input  logic              rq1_write,
  input  logic [ADDR_W-1:0] rq1_addr,
  input  logic [DATA_W-1:0] rq1_wdata,
  output logic              rq1_gnt,
  output logic [DATA_W-1:0] rq1_rdata,
  output logic              rq1_done,
  output logic              rq1_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_rd_addr,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data,
  input  logic              mem_wr_done,
  input  logic              mem_rd_done
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t state, state_nxt;

  logic [1:0]             pend, wr_req;
  logic [1:0][ADDR_W-1:0] rq_addr;
  logic [1:0][DATA_W-1:0] rq_wdata;
  logic [1:0][DATA_W-1:0] rdata_q;
  logic                   last, owner, op_wr, sel;
  logic                   match_done, timeout_hit;

  assign pend     = {rq1_read | rq1_write, rq0_read | rq0_write};
  assign wr_req   = {rq1_write, rq0_write};
  assign rq_addr  = {rq1_addr, rq0_addr};
  assign rq_wdata = {rq1_wdata, rq0_wdata};

  // Under contention the requester that was not served last wins.
  assign sel        = (pend == 2'b11) ? ~last : pend[1];
  assign match_done = op_wr ? mem_wr_done : mem_rd_done;

`ifdef MEM_PORT_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0] cnt;
  logic             err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 cnt <= '0;
    else if (state == ISSUE) cnt <= '0;
    else if (state == WAIT)  cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                               err_q <= 1'b0;
    else if (state == IDLE)                                err_q <= 1'b0;
    else if (state == WAIT && !match_done && timeout_hit) err_q <= 1'b1;
  end

  assign timeout_hit = (cnt == CNT_LAST);
  assign rq0_err     = rq0_done & err_q;
  assign rq1_err     = rq1_done & err_q;
`else
  assign timeout_hit = 1'b0;
  assign rq0_err     = 1'b0;
  assign rq1_err     = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (|pend) state_nxt = ISSUE;
      ISSUE: state_nxt = WAIT;
      WAIT:  if (match_done || timeout_hit) state_nxt = RESP;
      RESP:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last        <= 1'b1;
      owner       <= 1'b0;
      op_wr       <= 1'b0;
      mem_rd_addr <= '0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
      rdata_q     <= '0;
    end else begin
      case (state)
        IDLE: if (|pend) begin
          owner <= sel;
          op_wr <= wr_req[sel];
          if (wr_req[sel]) begin
            mem_wr_addr <= rq_addr[sel];
            mem_wr_data <= rq_wdata[sel];
          end else begin
            mem_rd_addr <= rq_addr[sel];
          end
        end
        WAIT: begin
          // Write completions leave the owner's read data untouched.
          if (match_done) begin
            if (!op_wr) rdata_q[owner] <= mem_rd_data;
          end else if (timeout_hit) begin
            rdata_q[owner] <= '0;
          end
        end
        RESP: last <= owner;
        default: ;
      endcase
    end
  end

  assign mem_write = (state == ISSUE) &  op_wr;
  assign mem_read  = (state == ISSUE) & ~op_wr;
  assign rq0_gnt   = (state == ISSUE) & ~owner;
  assign rq1_gnt   = (state == ISSUE) &  owner;
  assign rq0_done  = (state == RESP)  & ~owner;
  assign rq1_done  = (state == RESP)  &  owner;
  assign rq0_rdata = rdata_q[0];
  assign rq1_rdata = rdata_q[1];
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: transaction table plus reset, contention and spurious-done sequences.
module tb_mem_port_arbiter;
  logic        clk = 1'b0, rst = 1'b1;
  logic        rq0_read = 0, rq0_write = 0, rq1_read = 0, rq1_write = 0;
  logic [9:0]  rq0_addr = '0, rq1_addr = '0;
  logic [31:0] rq0_wdata = '0, rq1_wdata = '0;
  logic        rq0_gnt, rq0_done, rq0_err, rq1_gnt, rq1_done, rq1_err;
  logic [31:0] rq0_rdata, rq1_rdata;
  logic        mem_read, mem_write, mem_wr_done, mem_rd_done;
  logic [9:0]  mem_rd_addr, mem_wr_addr;
  logic [31:0] mem_wr_data, mem_rd_data;

  logic        m_wr_done = 0, m_rd_done = 0, inj_wr_done = 0, inj_rd_done = 0;
  logic        resp_en = 1'b1;
  bit          mem_ready = 1'b0;
  logic [31:0] mem_arr [1024];
  int          errs = 0, total = 0;

  assign mem_wr_done = m_wr_done | inj_wr_done;
  assign mem_rd_done = m_rd_done | inj_rd_done;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .rq0_read(rq0_read), .rq0_write(rq0_write), .rq0_addr(rq0_addr), .rq0_wdata(rq0_wdata),
    .rq0_gnt(rq0_gnt), .rq0_rdata(rq0_rdata), .rq0_done(rq0_done), .rq0_err(rq0_err),
    .rq1_read(rq1_read), .rq1_write(rq1_write), .rq1_addr(rq1_addr), .rq1_wdata(rq1_wdata),
    .rq1_gnt(rq1_gnt), .rq1_rdata(rq1_rdata), .rq1_done(rq1_done), .rq1_err(rq1_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rd_addr(mem_rd_addr),
    .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
    .mem_wr_done(mem_wr_done), .mem_rd_done(mem_rd_done)
  );

  // Memory model: one-cycle response; word a preloads to 0xC0DE0000 | a.
  always @(posedge clk) begin
    m_wr_done <= 1'b0;
    m_rd_done <= 1'b0;
    if (!mem_ready) begin
      for (int i = 0; i < 1024; i++) mem_arr[i] <= 32'hC0DE0000 | i;
      mem_ready <= 1'b1;
      mem_rd_data <= '0;
    end else if (resp_en) begin
      if (mem_write) begin mem_arr[mem_wr_addr] <= mem_wr_data; m_wr_done <= 1'b1; end
      if (mem_read)  begin mem_rd_data <= mem_arr[mem_rd_addr]; m_rd_done <= 1'b1; end
    end
  end

  typedef struct {
    int          id;
    bit          wr;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_req(input int id, input bit rd, input bit wr, input logic [9:0] a, input logic [31:0] d);
    if (id == 0) begin rq0_read = rd; rq0_write = wr; rq0_addr = a; rq0_wdata = d; end
    else         begin rq1_read = rd; rq1_write = wr; rq1_addr = a; rq1_wdata = d; end
  endtask

  function automatic logic gnt_of(input int id);  return id == 0 ? rq0_gnt  : rq1_gnt;  endfunction
  function automatic logic done_of(input int id); return id == 0 ? rq0_done : rq1_done; endfunction
  function automatic logic err_of(input int id);  return id == 0 ? rq0_err  : rq1_err;  endfunction
  function automatic logic [31:0] rdata_of(input int id); return id == 0 ? rq0_rdata : rq1_rdata; endfunction

  // One transaction from an idle arbiter; exp is read data (or held rdata for writes).
  task automatic txn(input int id, input bit wr, input logic [9:0] a, input logic [31:0] d,
                     input logic [31:0] exp, input int exp_lat, input bit exp_err);
    int cyc = 0, gnt_cyc = -1, done_cyc = -1, strobes = 0, wrong = 0;
    logic [9:0]  saddr = '0;
    logic [31:0] sdata = '0, drd = '0;
    logic        derr = 1'b0;
    @(negedge clk);
    set_req(id, !wr, wr, a, d);
    while (done_cyc < 0 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (gnt_of(id)) begin
        gnt_cyc = cyc;
        saddr = wr ? mem_wr_addr : mem_rd_addr;
        sdata = mem_wr_data;
      end
      if (wr ? mem_write : mem_read) strobes++;
      if (wr ? mem_read : mem_write) wrong++;
      if (done_of(id)) begin done_cyc = cyc; drd = rdata_of(id); derr = err_of(id); end
    end
    set_req(id, 0, 0, a, d);
    chk("grant_cycle", gnt_cyc, 1);
    chk("done_latency", done_cyc, exp_lat);
    chk("strobe_pulses", strobes, 1);
    chk("wrong_strobe", wrong, 0);
    chk("mem_addr", {22'd0, saddr}, {22'd0, a});
    if (wr) chk("mem_wr_data", sdata, d);
    chk(wr ? "rdata_held_on_write" : "rdata", drd, exp);
    chk("err_flag", {31'd0, derr}, {31'd0, exp_err});
  endtask

  initial begin
    int n0, n1, ng, cyc, seen, ovl;
    int gord [6];
    int gcyc [6];

    tbl[0] = '{0, 1'b1, 10'h000, 32'h7abc9c86, 32'h00000000};
    tbl[1] = '{0, 1'b0, 10'h000, 32'h0,        32'h7abc9c86};
    tbl[2] = '{1, 1'b1, 10'h3ff, 32'hdeadbeef, 32'h00000000};
    tbl[3] = '{1, 1'b0, 10'h3ff, 32'h0,        32'hdeadbeef};
    tbl[4] = '{0, 1'b0, 10'h005, 32'h0,        32'hC0DE0005};
    tbl[5] = '{1, 1'b1, 10'h000, 32'h12345678, 32'hdeadbeef};
    tbl[6] = '{1, 1'b0, 10'h000, 32'h0,        32'h12345678};
    tbl[7] = '{0, 1'b1, 10'h001, 32'h0badf00d, 32'hC0DE0005};
    tbl[8] = '{0, 1'b0, 10'h001, 32'h0,        32'h0badf00d};

    repeat (3) @(negedge clk);
    chk("reset_outputs", {31'd0, |{rq0_gnt, rq0_done, rq0_err, rq0_rdata, rq1_gnt, rq1_done, rq1_err,
        rq1_rdata, mem_read, mem_write, mem_rd_addr, mem_wr_addr, mem_wr_data}}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++)
      txn(tbl[i].id, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].exp, 3, 1'b0);

    // Reset in the middle of a stalled rq1 read.
    @(negedge clk);
    resp_en = 1'b0;
    set_req(1, 1, 0, 10'h009, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("reset_mid_outputs", {31'd0, |{rq0_gnt, rq0_done, rq0_err, rq0_rdata, rq1_gnt, rq1_done,
          rq1_err, rq1_rdata, mem_read, mem_write, mem_rd_addr, mem_wr_addr, mem_wr_data}}, 32'd0);
      @(negedge clk);
    end
    set_req(1, 0, 0, 0, 0);
    rst = 1'b0;
    inj_rd_done = 1'b1;
    @(negedge clk);
    inj_rd_done = 1'b0;
    resp_en = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (rq0_done | rq1_done | rq0_gnt | rq1_gnt) seen++;
    end
    chk("late_done_ignored", seen, 0);

    // Contention and round robin: both hold reads for three transactions each.
    set_req(0, 1, 0, 10'h005, 0);
    set_req(1, 1, 0, 10'h009, 0);
    n0 = 0; n1 = 0; ng = 0; cyc = 0; ovl = 0;
    while ((n0 < 3 || n1 < 3) && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (mem_read & mem_write) ovl++;
      if (rq0_gnt & rq1_gnt) ovl++;
      if ((rq0_gnt | rq1_gnt) && ng < 6) begin gord[ng] = rq1_gnt ? 1 : 0; gcyc[ng] = cyc; ng++; end
      if (rq0_done) begin
        chk("rr_rq0_rdata", rq0_rdata, 32'hC0DE0005);
        n0++;
        if (n0 == 3) set_req(0, 0, 0, 0, 0);
      end
      if (rq1_done) begin
        chk("rr_rq1_rdata", rq1_rdata, 32'hC0DE0009);
        n1++;
        if (n1 == 3) set_req(1, 0, 0, 0, 0);
      end
    end
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    chk("rr_grant_count", ng, 6);
    chk("rr_overlap", ovl, 0);
    for (int k = 0; k < ng; k++) chk($sformatf("rr_order_%0d", k), gord[k], k % 2);
    if (ng == 6) chk("rr_spacing", gcyc[5] - gcyc[0], 20);

    // Spurious done in IDLE, then wrong-type done during a write WAIT.
    repeat (2) @(negedge clk);
    inj_wr_done = 1'b1;
    @(negedge clk);
    inj_wr_done = 1'b0;
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (rq0_done | rq1_done | rq0_gnt | rq1_gnt) seen++;
    end
    chk("idle_done_ignored", seen, 0);
    resp_en = 1'b0;
    set_req(0, 0, 1, 10'h007, 32'h55aa55aa);
    @(negedge clk);
    chk("spur_gnt", {31'd0, rq0_gnt}, 32'd1);
    @(negedge clk);
    inj_rd_done = 1'b1;
    @(negedge clk);
    inj_rd_done = 1'b0;
    seen = 0;
    repeat (4) begin
      if (rq0_done) seen++;
      @(negedge clk);
    end
    chk("wrong_done_ignored", seen, 0);
    inj_wr_done = 1'b1;
    @(negedge clk);
    inj_wr_done = 1'b0;
    chk("wr_done_completes", {31'd0, rq0_done}, 32'd1);
    chk("wr_done_err", {31'd0, rq0_err}, 32'd0);
    set_req(0, 0, 0, 0, 0);
    resp_en = 1'b1;
    @(negedge clk);

`ifdef MEM_PORT_ARB_TIMEOUT_EN
    resp_en = 1'b0;
    txn(1, 1'b0, 10'h009, 0, 32'h0, 18, 1'b1);
    resp_en = 1'b1;
    txn(1, 1'b0, 10'h009, 0, 32'hC0DE0009, 3, 1'b0);
`else
    txn(1, 1'b0, 10'h009, 0, 32'hC0DE0009, 3, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errs, total);
    $finish;
  end
endmodule
